// File: rtl/clock_pkg.sv
// clock_pkg: key timing constants for the 50 MHz system and the auto-repeat phase encoding
package clock_pkg;
  localparam int DEB_CNT_20MS     = 1_000_000;
  localparam int HOLD_CNT_1S      = 50_000_000;
  localparam int REPEAT_CNT_200MS = 10_000_000;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } phase_t;
endpackage

// File: rtl/key_chan_my.sv
// key_chan_my: one key channel - synchroniser, debouncer, press/release strobes and auto-repeat
module key_chan_my
  import clock_pkg::*;
#(
  parameter int DEB_CNT    = DEB_CNT_20MS,
  parameter int HOLD_CNT   = HOLD_CNT_1S,
  parameter int REPEAT_CNT = REPEAT_CNT_200MS,
  parameter int DEB_WIDTH  = 20,
  parameter int HOLD_WIDTH = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_stable;
  logic [DEB_WIDTH-1:0]  r_deb_cnt;
  logic                  r_press;
  logic                  r_release;
  logic                  r_repeat;
  phase_t                r_phase;
  logic [HOLD_WIDTH-1:0] r_hold_cnt;
  logic                  w_mis;
  logic                  w_acc;
  logic                  w_top;
  logic [DEB_WIDTH-1:0]  w_deb_nxt;
  phase_t                w_phase_nxt;
  logic [HOLD_WIDTH-1:0] w_hold_nxt;
  logic                  w_rep_nxt;

  // debounce: count consecutive mismatching samples, accept the new level on the last one
  always_comb begin
    w_mis     = (~r_sync2) != r_stable;
    w_acc     = w_mis && (r_deb_cnt == DEB_WIDTH'(DEB_CNT - 1));
    w_deb_nxt = (!w_mis || w_acc) ? '0 : r_deb_cnt + 1'b1;
    w_top     = ((r_phase == HOLD) && (r_hold_cnt == HOLD_WIDTH'(HOLD_CNT - 1))) ||
                ((r_phase == REPEAT) && (r_hold_cnt == HOLD_WIDTH'(REPEAT_CNT - 1)));
  end

  // repeat phase next state: an accepted edge overrides any pending repeat strobe
  always_comb begin
    w_phase_nxt = r_phase;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = 1'b0;
    if (w_acc) begin
      w_phase_nxt = r_stable ? IDLE : HOLD;
      w_hold_nxt  = '0;
    end else if (r_phase != IDLE) begin
      if (w_top) begin
        w_phase_nxt = REPEAT;
        w_hold_nxt  = '0;
        w_rep_nxt   = 1'b1;
      end else begin
        w_hold_nxt = r_hold_cnt + 1'b1;
      end
    end
  end

  // state registers; synchroniser resets to the released level so a held key re-debounces
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b0;
      r_deb_cnt  <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
      r_phase    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_stable   <= r_stable ^ w_acc;
      r_deb_cnt  <= w_deb_nxt;
      r_press    <= w_acc && !r_stable;
      r_release  <= w_acc && r_stable;
      r_repeat   <= w_rep_nxt;
      r_phase    <= w_phase_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;
endmodule

// File: rtl/key_input_my.sv
// key_input_my: push-button conditioner producing clean level, press, release and repeat strobes per key
module key_input_my
  import clock_pkg::*;
#(
  parameter int NUM_KEYS   = 2,
  parameter int DEB_CNT    = DEB_CNT_20MS,
  parameter int HOLD_CNT   = HOLD_CNT_1S,
  parameter int REPEAT_CNT = REPEAT_CNT_200MS,
  parameter int DEB_WIDTH  = 20,
  parameter int HOLD_WIDTH = 26
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic [NUM_KEYS-1:0] o_repeat
);
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_chan_my #(
      .DEB_CNT   (DEB_CNT),
      .HOLD_CNT  (HOLD_CNT),
      .REPEAT_CNT(REPEAT_CNT),
      .DEB_WIDTH (DEB_WIDTH),
      .HOLD_WIDTH(HOLD_WIDTH)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_n  (i_key_n[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_repeat (o_repeat[g])
    );
  end
endmodule

// File: tb/tb_key_input_my.sv
// tb_key_input_my: scoreboard bench for key_input_my with short debounce/hold/repeat timing
module tb_key_input_my;
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [1:0] i_key_n;
  logic [1:0] o_level, o_press, o_release, o_repeat;

  typedef struct {
    int         c;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] q;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [1:0] exp_level = 2'b00;

  key_input_my #(
    .NUM_KEYS  (2),
    .DEB_CNT   (4),
    .HOLD_CNT  (10),
    .REPEAT_CNT(3),
    .DEB_WIDTH (3),
    .HOLD_WIDTH(4)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_key_n  (i_key_n),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_repeat (o_repeat)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  function automatic void chk(string nm, logic [1:0] act, logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
    end
  endfunction

  // k: 0 = press, 1 = release, 2 = repeat; events on the same cycle are merged
  function automatic void add(int c, int k, int ch);
    int  i;
    ev_t e;
    for (i = 0; i < sb.size(); i++) if (sb[i].c >= c) break;
    if (!(i < sb.size() && sb[i].c == c)) begin
      e = '{c, 2'b00, 2'b00, 2'b00};
      sb.insert(i, e);
    end
    e = sb[i];
    if (k == 0) e.p[ch] = 1'b1;
    if (k == 1) e.r[ch] = 1'b1;
    if (k == 2) e.q[ch] = 1'b1;
    sb[i] = e;
  endfunction

  // key driven low at cycle n and high again at cycle m: press n+6, repeats n+16 then every 3, release m+6 wins
  function automatic void key_seq(int ch, int n, int m);
    add(n + 6, 0, ch);
    for (int c = n + 16; c < m + 6; c += 3) add(c, 2, ch);
    add(m + 6, 1, ch);
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  always @(negedge i_clk) begin
    ev_t e;
    e = '{cyc, 2'b00, 2'b00, 2'b00};
    while (sb.size() > 0 && sb[0].c < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL stale_event cyc=%0d got=none exp=event@%0d", cyc, sb[0].c);
      void'(sb.pop_front());
    end
    if (!i_rst_n) begin
      exp_level = 2'b00;
    end else begin
      if (sb.size() > 0 && sb[0].c == cyc) e = sb.pop_front();
      exp_level = (exp_level | e.p) & ~e.r;
    end
    chk("level", o_level, exp_level);
    chk("press", o_press, e.p);
    chk("release", o_release, e.r);
    chk("repeat", o_repeat, e.q);
  end

  initial begin
    int n;
    int r;
    i_rst_n = 1'b0;
    i_key_n = 2'b11;
    #3;
    chk("rst_level", o_level, 2'b00);
    chk("rst_press", o_press, 2'b00);
    chk("rst_release", o_release, 2'b00);
    chk("rst_repeat", o_repeat, 2'b00);
    step(2);
    i_rst_n = 1'b1;
    step(3);
    n = cyc;
    i_key_n[0] = 1'b0;
    key_seq(0, n, n + 8);
    step(8);
    i_key_n[0] = 1'b1;
    step(12);
    for (int i = 0; i < 15; i++) begin
      i_key_n[0] = ~i_key_n[0];
      step(2);
    end
    i_key_n[0] = 1'b1;
    step(10);
    n = cyc;
    i_key_n[0] = 1'b0;
    key_seq(0, n, n + 45);
    step(45);
    i_key_n[0] = 1'b1;
    step(12);
    n = cyc;
    i_key_n[0] = 1'b0;
    key_seq(0, n, n + 22);
    step(22);
    i_key_n[0] = 1'b1;
    step(12);
    n = cyc;
    i_key_n = 2'b00;
    key_seq(0, n, n + 30);
    key_seq(1, n, n + 20);
    step(20);
    i_key_n[1] = 1'b1;
    step(10);
    i_key_n[0] = 1'b1;
    step(12);
    n = cyc;
    i_key_n[0] = 1'b0;
    add(n + 6, 0, 0);
    add(n + 16, 2, 0);
    add(n + 19, 2, 0);
    step(19);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_level", o_level, 2'b00);
    chk("async_press", o_press, 2'b00);
    chk("async_release", o_release, 2'b00);
    chk("async_repeat", o_repeat, 2'b00);
    step(2);
    r = cyc;
    i_rst_n = 1'b1;
    key_seq(0, r, r + 10);
    step(10);
    i_key_n[0] = 1'b1;
    step(12);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
